// File: rtl/mprj_chkmon_pkg.sv
// mprj_chkmon_pkg: state encoding, register map, control/status bit positions and byte-lane merge for the checkpoint monitor
package mprj_chkmon_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;
  typedef enum logic [1:0] {IDLE = ST_IDLE, WAIT = ST_WAIT, PASS = ST_PASS, FAIL = ST_FAIL} chkmon_state_e;
  localparam logic [7:0] OFF_CTRL    = 8'h00;
  localparam logic [7:0] OFF_STATUS  = 8'h04;
  localparam logic [7:0] OFF_TIMEOUT = 8'h08;
  localparam logic [7:0] OFF_COUNT   = 8'h0C;
  localparam logic [7:0] OFF_CODE    = 8'h10;
  localparam int CTRL_ARM   = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int STAT_IDX   = 4;
  localparam int STAT_PASS  = 8;
  localparam int STAT_FAIL  = 9;
  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] din, input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction
endpackage

// File: rtl/chkmon_wb_regs.sv
// chkmon_wb_regs: Wishbone decode, single-cycle ack, TIMEOUT/COUNT/CODE register file and readback
// Ports: clk/rst_n (async active-low); cyc/stb/we/sel/adr/dat Wishbone request; ack/rdat response;
//        status readback word in; arm/clear CTRL pulses, timeout/count/code register values out.
module chkmon_wb_regs
  import mprj_chkmon_pkg::*;
#(
  parameter int          CHECK_W   = 16,
  parameter int          DEPTH     = 4,
  parameter int          TIMEOUT_W = 24,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cyc,
  input  logic                             stb,
  input  logic                             we,
  input  logic [3:0]                       sel,
  input  logic [31:0]                      adr,
  input  logic [31:0]                      dat,
  input  logic [31:0]                      status,
  output logic                             ack,
  output logic [31:0]                      rdat,
  output logic                             arm,
  output logic                             clear,
  output logic [TIMEOUT_W-1:0]             timeout,
  output logic [4:0]                       count,
  output logic [DEPTH-1:0][CHECK_W-1:0]    code
);
  logic [7:0] off;
  logic hit, wr;
  logic [31:0] rd;
  assign off = adr[7:0];
  assign hit = cyc & stb & (adr[31:8] == BASE_ADDR[31:8]);
  // the master holds the request through the ack cycle, so writes commit on that edge
  assign wr = ack & hit & we;
  assign arm = wr & off == OFF_CTRL & dat[CTRL_ARM];
  assign clear = wr & off == OFF_CTRL & dat[CTRL_CLEAR];
  assign rdat = ack ? rd : '0;
  always_comb begin
    rd = off == OFF_STATUS ? status : off == OFF_TIMEOUT ? 32'(timeout) : off == OFF_COUNT ? 32'(count) : '0;
    for (int i = 0; i < DEPTH; i++) if (off == 8'(OFF_CODE + 4*i)) rd = 32'(code[i]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ack <= 1'b0;
      timeout <= '0;
      count <= 5'd1;
      code <= '0;
    end else begin
      ack <= hit & ~ack;
      if (wr && off == OFF_TIMEOUT) timeout <= TIMEOUT_W'(byte_merge(32'(timeout), dat, sel));
      if (wr && off == OFF_COUNT) count <= 5'(byte_merge(32'(count), dat, sel));
      for (int i = 0; i < DEPTH; i++)
        if (wr && off == 8'(OFF_CODE + 4*i)) code[i] <= CHECK_W'(byte_merge(32'(code[i]), dat, sel));
    end
endmodule

// File: rtl/mprj_checkpoint_monitor.sv
// mprj_checkpoint_monitor: checks that a programmed code sequence appears in order on check_i, each within a timeout
// Ports: wb_clk_i/wb_rstn_i clock and async active-low reset; wbs_* Wishbone slave; check_i monitored bus;
//        pass_o/fail_o sticky results, irq_o = pass_o | fail_o.
// Build option CHKMON_SYNC_EN: adds a 2-flop synchronizer on check_i (one cycle more match latency).
module mprj_checkpoint_monitor
  import mprj_chkmon_pkg::*;
#(
  parameter int          CHECK_W   = 16,
  parameter int          DEPTH     = 4,
  parameter int          TIMEOUT_W = 24,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic               wb_clk_i,
  input  logic               wb_rstn_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [CHECK_W-1:0] check_i,
  output logic               pass_o,
  output logic               fail_o,
  output logic               irq_o
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic arm, clear, match;
  logic [TIMEOUT_W-1:0] timeout, cnt;
  logic [4:0] count;
  logic [DEPTH-1:0][CHECK_W-1:0] code;
  logic [CHECK_W-1:0] samp, prev;
  logic [1:0] state;
  logic [IW-1:0] idx, last;
  logic [31:0] status;
  chkmon_wb_regs #(.CHECK_W(CHECK_W), .DEPTH(DEPTH), .TIMEOUT_W(TIMEOUT_W), .BASE_ADDR(BASE_ADDR)) u_regs (
    .clk(wb_clk_i), .rst_n(wb_rstn_i), .cyc(wbs_cyc_i), .stb(wbs_stb_i), .we(wbs_we_i), .sel(wbs_sel_i),
    .adr(wbs_adr_i), .dat(wbs_dat_i), .status(status), .ack(wbs_ack_o), .rdat(wbs_dat_o),
    .arm(arm), .clear(clear), .timeout(timeout), .count(count), .code(code)
  );
`ifdef CHKMON_SYNC_EN
  logic [CHECK_W-1:0] meta;
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i)
    if (!wb_rstn_i) begin
      meta <= '0;
      samp <= '0;
    end else begin
      meta <= check_i;
      samp <= meta;
    end
`else
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i)
    if (!wb_rstn_i) samp <= '0;
    else samp <= check_i;
`endif
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i)
    if (!wb_rstn_i) prev <= '0;
    else prev <= samp;
  // a value must be stable for two samples, so a one-cycle multi-bit transition never matches
  assign match = samp == prev && samp == code[idx];
  assign last = count == 5'd0 ? '0 : count > 5'(DEPTH) ? IW'(DEPTH - 1) : IW'(count - 5'd1);
  assign irq_o = pass_o | fail_o;
  always_comb begin
    status = '0;
    status[1:0] = state;
    status[STAT_IDX +: 4] = 4'(idx);
    status[STAT_PASS] = pass_o;
    status[STAT_FAIL] = fail_o;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i)
    if (!wb_rstn_i) begin
      state <= ST_IDLE;
      idx <= '0;
      cnt <= '0;
      pass_o <= 1'b0;
      fail_o <= 1'b0;
    end else begin
      pass_o <= state == ST_PASS;
      fail_o <= state == ST_FAIL;
      if (clear) begin
        state <= ST_IDLE;
        idx <= '0;
      end else if (arm) begin
        state <= ST_WAIT;
        idx <= '0;
        cnt <= timeout;
      end else if (state == ST_WAIT) begin
        if (match) begin
          if (idx == last) state <= ST_PASS;
          else begin
            idx <= idx + 1'b1;
            cnt <= timeout;
          end
        end else if (timeout != '0) begin
          // the FAIL transition lands on the same edge the counter reaches zero
          cnt <= cnt - 1'b1;
          if (cnt <= TIMEOUT_W'(1)) state <= ST_FAIL;
        end
      end
    end
endmodule

// File: tb/tb_mprj_checkpoint_monitor.sv
// tb_mprj_checkpoint_monitor: directed self-checking bench for the checkpoint monitor
module tb_mprj_checkpoint_monitor;
  localparam logic [31:0] B = 32'h3000_0000;
`ifdef CHKMON_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  logic clk = 1'b0, rst_n = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0] sel = 4'h0;
  logic [31:0] adr = '0, dat = '0, rdat;
  logic [15:0] chk = '0;
  logic ack, pass_o, fail_o, irq_o;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mprj_checkpoint_monitor dut (
    .wb_clk_i(clk), .wb_rstn_i(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(rdat), .check_i(chk),
    .pass_o(pass_o), .fail_o(fail_o), .irq_o(irq_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    int n = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 8);
    check("ack", 32'(ack), 32'd1);
    r = rdat;
    @(posedge clk);
    #1 cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    check("ack_1cyc", 32'(ack), 32'd0);
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] r;
    wb(1'b1, a, d, s, r);
  endtask
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    wb(1'b0, a, 32'd0, 4'hF, r);
    check(tag, r, exp);
  endtask
  task automatic prog(input logic [31:0] t, input logic [4:0] n);
    chk = '0;
    repeat (3) @(negedge clk);
    wr(B + 32'h10, 32'hAB60);
    wr(B + 32'h14, 32'hAB61);
    wr(B + 32'h0C, 32'(n));
    wr(B + 32'h08, t);
    wr(B, 32'h1);
  endtask
  task automatic async_rst(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_pass"}, 32'(pass_o), 32'd0);
    check({tag, "_fail"}, 32'(fail_o), 32'd0);
    check({tag, "_irq"}, 32'(irq_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd({tag, "_status"}, B + 32'h04, 32'h0);
    rd({tag, "_timeout"}, B + 32'h08, 32'h0);
    rd({tag, "_count"}, B + 32'h0C, 32'h1);
    rd({tag, "_code1"}, B + 32'h14, 32'h0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_pass", 32'(pass_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    rst_n = 1'b1;
    rd("rst_status", B + 32'h04, 32'h0);
    rd("rst_timeout", B + 32'h08, 32'h0);
    rd("rst_count", B + 32'h0C, 32'h1);
    rd("rst_code0", B + 32'h10, 32'h0);
    rd("ctrl_reads0", B, 32'h0);
    rd("unmapped", B + 32'h80, 32'h0);
    wr(B + 32'h08, 32'h1234);
    wr(B + 32'h08, 32'hFFFF_FFFF, 4'h1);
    rd("sel_merge", B + 32'h08, 32'h12FF);
    // in-order sequence, second code 300 cycles after the first
    prog(1000, 2);
    rd("armed", B + 32'h04, 32'h001);
    chk = 16'hAB60;
    repeat (300) @(negedge clk);
    chk = 16'hAB61;
    repeat (LAT) @(posedge clk);
    @(negedge clk) check("seq_pass_early", 32'(pass_o), 32'd0);
    @(negedge clk) check("seq_pass", 32'(pass_o), 32'd1);
    check("seq_fail", 32'(fail_o), 32'd0);
    check("seq_irq", 32'(irq_o), 32'd1);
    rd("seq_status", B + 32'h04, 32'h112);
    // second code never arrives: FAIL state TIMEOUT cycles after the idx-1 reload
    prog(20, 2);
    chk = 16'hAB60;
    repeat (LAT + 20) @(posedge clk);
    @(negedge clk) check("to_fail_early", 32'(fail_o), 32'd0);
    @(negedge clk) check("to_fail", 32'(fail_o), 32'd1);
    check("to_pass", 32'(pass_o), 32'd0);
    rd("to_status", B + 32'h04, 32'h213);
    // match arrives on the very cycle the counter would expire
    prog(10, 2);
    chk = 16'hAB60;
    repeat (10) @(posedge clk);
    @(negedge clk) chk = 16'hAB61;
    repeat (LAT) @(posedge clk);
    @(negedge clk) check("tie_fail_early", 32'(fail_o), 32'd0);
    @(negedge clk) check("tie_pass", 32'(pass_o), 32'd1);
    check("tie_fail", 32'(fail_o), 32'd0);
    rd("tie_status", B + 32'h04, 32'h112);
    wr(B, 32'h3);
    rd("clear_wins", B + 32'h04, 32'h0);
    check("clear_pass", 32'(pass_o), 32'd0);
    // one-cycle glitch ignored, two-cycle hold accepted
    prog(0, 2);
    chk = 16'hAB60;
    @(negedge clk) chk = '0;
    repeat (5) @(negedge clk);
    rd("glitch", B + 32'h04, 32'h001);
    @(negedge clk) chk = 16'hAB60;
    repeat (2) @(negedge clk);
    chk = '0;
    repeat (5) @(negedge clk);
    rd("hold2", B + 32'h04, 32'h011);
    // timeout disabled: waits forever
    prog(0, 2);
    chk = 16'hAB60;
    repeat (50000) @(negedge clk);
    rd("notimeout", B + 32'h04, 32'h011);
    check("notimeout_fail", 32'(fail_o), 32'd0);
    chk = '0;
    repeat (3) @(negedge clk);
    wr(B, 32'h1);
    rd("rearm_wait", B + 32'h04, 32'h001);
    chk = 16'hAB60;
    repeat (6) @(negedge clk);
    rd("midwait", B + 32'h04, 32'h011);
    chk = '0;
    async_rst("rst_wait");
    // COUNT above DEPTH clamps to 4; CODE2/3 are 0 after reset
    prog(0, 9);
    chk = 16'hAB60;
    repeat (6) @(negedge clk);
    chk = 16'hAB61;
    repeat (6) @(negedge clk);
    chk = '0;
    repeat (10) @(negedge clk);
    rd("clamp_hi", B + 32'h04, 32'h132);
    // COUNT 0 acts as length 1
    prog(0, 0);
    chk = 16'hAB60;
    repeat (6) @(negedge clk);
    check("clamp0_pass", 32'(pass_o), 32'd1);
    rd("clamp0_status", B + 32'h04, 32'h102);
    async_rst("rst_pass");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
